// File: rtl/word_exp.sv
// word_exp: converts an operand into the Montgomery domain by computing
// Z = A * 2^(R*NWORDS) mod q with one modular doubling per clock.
// Handshake: in_valid/in_ready on the input side and out_valid/out_ready on
// the output side. A new operand can be loaded in the same cycle the
// previous result is taken.
module word_exp #(
  parameter int LOGQ   = 60,
  parameter int R      = 34,
  parameter int NWORDS = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [LOGQ-1:0] q,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [LOGQ-1:0] A,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [LOGQ-1:0] Z,
  output logic            busy
);

  localparam int ITER  = R * NWORDS;
  localparam int CNT_W = $clog2(ITER + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [LOGQ-1:0]   r_acc;
  logic [LOGQ-1:0]   r_q;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_accept;
  logic              w_last;
  logic [LOGQ-1:0]   w_next_acc;

  // One modular doubling step. The doubled value keeps its carry bit, so
  // the compare and subtract are done one bit wider than the modulus.
  // With acc < m the result is also < m, so the top bit of the difference
  // is always zero and can be dropped.
  function automatic logic [LOGQ-1:0] dbl_mod(input logic [LOGQ-1:0] acc,
                                              input logic [LOGQ-1:0] m);
    logic [LOGQ:0] t;
    logic [LOGQ:0] mx;
    logic [LOGQ:0] d;
    t  = {acc, 1'b0};
    mx = {1'b0, m};
    d  = t - mx;
    if (t >= mx) begin
      dbl_mod = d[LOGQ-1:0];
    end else begin
      dbl_mod = t[LOGQ-1:0];
    end
  endfunction

  // Handshake and status flags, decoded from the registered state only
  always_comb begin
    in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
    out_valid = (r_state == S_DONE);
    busy      = (r_state == S_RUN);
    Z         = r_acc;
  end

  // Accept condition, last-step detect and the next accumulator value
  always_comb begin
    w_accept   = in_valid && in_ready;
    w_last     = (r_cnt == CNT_W'(ITER - 1));
    w_next_acc = dbl_mod(r_acc, r_q);
  end

  // Control FSM plus accumulator/modulus/counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_q     <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_acc   <= A;
            r_q     <= q;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc <= w_next_acc;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          // Result taken: either reload immediately or fall back to idle
          if (out_ready) begin
            if (in_valid) begin
              r_acc   <= A;
              r_q     <= q;
              r_cnt   <= '0;
              r_state <= S_RUN;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_word_exp.sv
// Bench for word_exp with LOGQ=8, R=4, NWORDS=1 (four doubling steps).
// Expected results are pushed to a queue on each input handshake and popped
// on each output handshake; directed traces also check intermediate values.
module tb_word_exp;

  localparam int LOGQ   = 8;
  localparam int R      = 4;
  localparam int NWORDS = 1;
  localparam int ITER   = R * NWORDS;

  logic            clk;
  logic            rst;
  logic [LOGQ-1:0] q;
  logic            in_valid;
  logic            in_ready;
  logic [LOGQ-1:0] A;
  logic            out_valid;
  logic            out_ready;
  logic [LOGQ-1:0] Z;
  logic            busy;

  int n_checks;
  int n_errors;
  int n_in;
  int n_out;
  int n_abort;
  logic [31:0] sb[$];
  bit rand_on;

  word_exp #(.LOGQ(LOGQ), .R(R), .NWORDS(NWORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .q         (q),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Z         (Z),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: handshakes are observed at the falling edge, where inputs
  // and DUT outputs are stable ahead of the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      n_abort += sb.size();
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        check_eq("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          check_eq("sb_z", 32'(Z), sb.pop_front());
        end
        n_out++;
      end
      if (in_valid && in_ready) begin
        sb.push_back((32'(A) << ITER) % 32'(q));
        n_in++;
      end
    end
  end

  // Present one operand and hold it until accepted; returns just after the accept edge
  task automatic send(input logic [LOGQ-1:0] qv, input logic [LOGQ-1:0] av);
    int k;
    q        = qv;
    A        = av;
    in_valid = 1'b1;
    k = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      k++;
      if (k > 100) begin
        check_eq("in_ready_wait", 32'(in_ready), 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Full operation with out_ready high; checks every intermediate acc value
  // and that out_valid rises exactly ITER edges after accept. Inputs are
  // scrambled during RUN to show they are ignored.
  task automatic trace(input logic [LOGQ-1:0] qv, input logic [LOGQ-1:0] av,
                       input logic [LOGQ-1:0] e1, input logic [LOGQ-1:0] e2,
                       input logic [LOGQ-1:0] e3, input logic [LOGQ-1:0] e4);
    logic [LOGQ-1:0] ev[4];
    ev[0] = e1; ev[1] = e2; ev[2] = e3; ev[3] = e4;
    out_ready = 1'b1;
    send(qv, av);
    check_eq("acc_load", 32'(Z), 32'(av));
    check_eq("busy_run", 32'(busy), 32'd1);
    q = 8'd7;
    A = 8'd200;
    in_valid = 1'b1;
    for (int i = 1; i <= ITER; i++) begin
      @(posedge clk);
      #1;
      check_eq("acc_step", 32'(Z), 32'(ev[i-1]));
      check_eq("ov_latency", 32'(out_valid), 32'(i == ITER));
      if (i >= 3) in_valid = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // Stall generator for the random phase
  initial begin
    wait (rand_on);
    while (rand_on) begin
      @(posedge clk);
      #1;
      if (rand_on) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    logic [LOGQ-1:0] qv;
    logic [LOGQ-1:0] av;
    int guard;
    n_checks = 0; n_errors = 0; n_in = 0; n_out = 0; n_abort = 0;
    rand_on = 1'b0;
    rst = 1'b1; q = '0; A = '0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_z", 32'(Z), 32'd0);

    // Basic, carry-path and zero/max-operand traces
    trace(8'd13, 8'd5, 8'd10, 8'd7, 8'd1, 8'd2);
    trace(8'd255, 8'd254, 8'd253, 8'd251, 8'd247, 8'd239);
    trace(8'd13, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    trace(8'd13, 8'd12, 8'd11, 8'd9, 8'd5, 8'd10);
    @(posedge clk);
    #1;
    check_eq("idle_after_take", 32'(in_ready), 32'd1);

    // Output stall: result holds, new input is refused, then a same-cycle
    // output/input handshake reloads without a bubble
    out_ready = 1'b0;
    send(8'd13, 8'd5);
    repeat (ITER) @(posedge clk);
    #1;
    q = 8'd13; A = 8'd12; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_eq("stall_ov", 32'(out_valid), 32'd1);
      check_eq("stall_z", 32'(Z), 32'd2);
      check_eq("stall_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_eq("b2b_busy", 32'(busy), 32'd1);
    check_eq("b2b_load", 32'(Z), 32'd12);
    repeat (ITER - 1) @(posedge clk);
    #1;
    check_eq("b2b_not_yet", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check_eq("b2b_ov", 32'(out_valid), 32'd1);
    check_eq("b2b_z", 32'(Z), 32'd10);
    @(posedge clk);
    #1;

    // Reset at the second RUN edge aborts the operation
    send(8'd13, 8'd5);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("abort_in_ready", 32'(in_ready), 32'd1);
    check_eq("abort_out_valid", 32'(out_valid), 32'd0);
    check_eq("abort_z", 32'(Z), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    trace(8'd13, 8'd5, 8'd10, 8'd7, 8'd1, 8'd2);
    @(posedge clk);
    #1;

    // Random regression with output stalls
    rand_on = 1'b1;
    for (int t = 0; t < 60; t++) begin
      qv = 8'(($urandom_range(1, 127) * 2) + 1);
      av = 8'($urandom_range(0, int'(qv) - 1));
      send(qv, av);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    rand_on = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b1;
    guard = 0;
    while ((sb.size() != 0 || out_valid || busy) && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check_eq("drain_done", 32'(sb.size()), 32'd0);
    check_eq("one_out_per_in", 32'(n_out), 32'(n_in - n_abort));
    check_eq("final_idle", 32'(in_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/word_exp.md
WORD_EXP -- requirements
Module: word_exp

Interface
REQ-001 Parameter LOGQ, default 60: modulus and operand width in bits.
REQ-002 Parameter R, default 34: bits per Montgomery word; same meaning as in the word-level reducer.
REQ-003 Parameter NWORDS, default 2: number of words; the block multiplies by 2^(R*NWORDS).
REQ-004 Derived ITER = R*NWORDS (iteration count); counter width = clog2(ITER+1).
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 q  input  LOGQ  odd modulus; sampled only on input accept.
REQ-008 in_valid  input  1  A is valid.
REQ-009 in_ready  output  1  block can accept A.
REQ-010 A  input  LOGQ  operand; A < q required; A >= q gives an undefined result.
REQ-011 out_valid  output  1  Z is valid.
REQ-012 out_ready  input  1  consumer accepts Z.
REQ-013 Z  output  LOGQ  result A*2^(R*NWORDS) mod q, i.e. A converted into the Montgomery domain.
REQ-014 busy  output  1  high in RUN state.

Function
REQ-015 FSM states: IDLE, RUN, DONE; registers acc[LOGQ-1:0], q_r[LOGQ-1:0], cnt.
REQ-016 in_ready = (state==IDLE) | (state==DONE & out_ready); out_valid = (state==DONE); busy = (state==RUN); all are decoded from registered state only.
REQ-017 Accept (in_valid & in_ready at an edge): acc<=A, q_r<=q, cnt<=0, state<=RUN.
REQ-018 Each RUN edge performs one step: t = {acc,1'b0} (LOGQ+1 bits); acc <= (t >= q_r) ? t - q_r : t[LOGQ-1:0]; cnt <= cnt+1.
REQ-019 The comparison and subtraction are LOGQ+1 bits wide; the doubled value never truncates before the compare.
REQ-020 On the edge where cnt==ITER-1, the last step executes and state<=DONE.
REQ-021 Latency: out_valid is high exactly ITER edges after the accept edge; throughput is one result per ITER+1 cycles when back-to-back.
REQ-022 Z = acc in every state; it is stable while out_valid & !out_ready.
REQ-023 DONE & out_ready & !in_valid -> IDLE at the next edge.
REQ-024 DONE & out_ready & in_valid -> this is a simultaneous output and input handshake; the new A is loaded and the next state is RUN (no bubble).
REQ-025 DONE & !out_ready -> remain in DONE and ignore in_valid.
REQ-026 in_valid while busy is ignored; changes on q or A during RUN do not affect the result.
REQ-027 Invariant: acc < q_r after every step, given A < q.

Reset
REQ-028 While rst is high at an edge: state<=IDLE, acc<=0, q_r<=0, cnt<=0.
REQ-029 After reset: in_ready=1, out_valid=0, busy=0, Z=0.
REQ-030 Reset during RUN or DONE aborts the operation; no out_valid follows for the aborted operand.
REQ-031 rst has priority over any handshake in the same cycle.

Verification (LOGQ=8, R=4, NWORDS=1, so ITER=4)
REQ-032 q=13, A=5 accepted, out_ready=1 -> out_valid high 4 edges after accept, Z=2 (intermediate acc values 10, 7, 1, 2).
REQ-033 q=255, A=254 -> Z=239 (acc values 253, 251, 247, 239); this checks the LOGQ+1-bit compare path.
REQ-034 q=13, A=0 -> Z=0; then A=12 -> Z=10.
REQ-035 out_ready=0 for 5 cycles in DONE -> out_valid and Z=2 hold, in_ready=0, and in_valid is ignored. Then out_ready=1 with in_valid=1 and A=12 -> A=12 is accepted in the same cycle, and Z=10 appears 4 edges later.
REQ-036 Reset at the 2nd RUN edge -> the next cycle shows in_ready=1, out_valid=0, Z=0. A new operand A=5 then yields Z=2 with nominal latency.
REQ-037 Random regression: q odd, A<q, random out_ready stalls. Check Z against the (A << ITER) mod q model, check one output per accepted input, and check in-order delivery.
